// File: rtl/if_stage.sv
// if_stage: instruction fetch with PC register, IF/ID register and RUN/HALT FSM; IF_STAGE_PERF_CNT_EN adds stall/flush counters
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
`ifdef IF_STAGE_PERF_CNT_EN
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_cycles,
`endif
  output logic        halted
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_n;
  logic [31:0] pc4, pc_n, instr_n, p4_n;
  logic valid_n, in_halt, hold, fetch;
  assign imem_addr = pc_out;
  assign halted = state == HALT;
  assign pc4 = pc_out + 32'd4;
  always_comb begin
    in_halt = state == HALT;
    hold = !redirect && !in_halt && stall;
    fetch = !redirect && !in_halt && !stall;
    pc_n = redirect ? (redirect_target & ~32'h3) : fetch ? pc4 : pc_out;
    instr_n = fetch ? imem_rdata : hold ? ifid_instr : NOP_WORD;
    p4_n = fetch ? pc4 : hold ? ifid_pc_plus4 : 32'h0;
    valid_n = fetch ? 1'b1 : hold ? ifid_valid : 1'b0;
    state_n = redirect ? RUN : fetch ? (imem_rdata == HALT_WORD ? HALT : RUN) : state;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_out <= RESET_PC;
      ifid_instr <= NOP_WORD;
      ifid_pc_plus4 <= 32'h0;
      ifid_valid <= 1'b0;
      state <= RUN;
    end else begin
      pc_out <= pc_n;
      ifid_instr <= instr_n;
      ifid_pc_plus4 <= p4_n;
      ifid_valid <= valid_n;
      state <= state_n;
    end
  end
`ifdef IF_STAGE_PERF_CNT_EN
  // both counters saturate rather than wrap
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= 16'h0;
      flush_cycles <= 16'h0;
    end else begin
      stall_cycles <= (hold && stall_cycles != 16'hFFFF) ? stall_cycles + 16'd1 : stall_cycles;
      flush_cycles <= (redirect && flush_cycles != 16'hFFFF) ? flush_cycles + 16'd1 : flush_cycles;
    end
  end
`endif
endmodule
